// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the quantr-i fetch PC generator.
// Holds the PC state encoding, the redirect-type encoding and the
// INSTR_BYTES legality check used by pc_gen.
package pc_pkg;

    typedef enum logic [1:0] {
        RESET,
        BOOT,
        RUN,
        HOLD
    } pc_state_t;

    typedef enum logic [1:0] {
        NONE,
        JUMP,
        TRAP
    } redirect_t;

    localparam int INSTR_BYTES_SHORT = 2;
    localparam int INSTR_BYTES_WORD  = 4;

    function automatic bit instr_bytes_legal(input int bytes);
        return (bytes == INSTR_BYTES_SHORT) || (bytes == INSTR_BYTES_WORD);
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: one-entry pending-redirect register for pc_gen.
// A redirect arriving during a stall is parked here until the stall
// releases. Newer redirects overwrite older ones, except that a parked
// trap is never displaced by a jump.
module pc_redirect_buf
    import pc_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            capture,
    input  redirect_t       capture_kind,
    input  logic [XLEN-1:0] capture_target,
    input  logic            clear,
    output redirect_t       pend_kind,
    output logic [XLEN-1:0] pend_target
);

    redirect_t       kind_q;
    logic [XLEN-1:0] target_q;
    logic            trap_protected;

    // a parked trap outranks any incoming jump
    always_comb begin
        trap_protected = (kind_q == TRAP) && (capture_kind != TRAP);
    end

    // buffer register: reset/clear empties it, capture loads newest unless trap-protected
    always_ff @(posedge clk) begin
        if (rst) begin
            kind_q   <= NONE;
            target_q <= '0;
        end else if (clear) begin
            kind_q   <= NONE;
        end else if (capture && !trap_protected) begin
            kind_q   <= capture_kind;
            target_q <= capture_target;
        end
    end

    assign pend_kind   = kind_q;
    assign pend_target = target_q;

endmodule

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the quantr-i fetch stage.
// Holds and advances the fetch PC behind a valid/ready handshake, honours
// stall[0], and buffers redirects that arrive during a stall.
// Optional feature macro: PC_TRAP_EN adds the trap_valid/trap_vector
// redirect with the highest non-reset priority.
module pc_gen #(
    parameter int              XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INSTR_BYTES  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      stall,
    input  logic            jump_sign,
    input  logic [XLEN-1:0] jump_address,
`ifdef PC_TRAP_EN
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
`endif
    input  logic            fetch_ready,
    output logic [XLEN-1:0] pc,
    output logic            ce,
    output logic            fetch_valid,
    output logic            misalign
);

    import pc_pkg::*;

    localparam bit              INSTR_BYTES_OK = instr_bytes_legal(INSTR_BYTES);
    localparam logic [XLEN-1:0] STEP           = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK     = ~(XLEN'(INSTR_BYTES - 1));

    if (!INSTR_BYTES_OK) begin : g_illegal_instr_bytes
        $error("pc_gen: INSTR_BYTES must be 2 or 4");
    end

    pc_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            misalign_q, misalign_d;

    logic            hold_req;
    logic            live;
    logic            trap_req;
    logic [XLEN-1:0] trap_target;
    redirect_t       fresh_kind;
    logic [XLEN-1:0] fresh_target;
    logic            buf_capture;
    logic            buf_clear;
    redirect_t       pend_kind;
    logic [XLEN-1:0] pend_target;
    logic            apply;
    logic [XLEN-1:0] apply_target;
    logic            unused_stall;

    assign hold_req     = stall[0];
    assign unused_stall = |stall[5:1];
    assign live         = (state_q == RUN) || (state_q == HOLD);

`ifdef PC_TRAP_EN
    assign trap_req    = trap_valid;
    assign trap_target = trap_vector;
`else
    assign trap_req    = 1'b0;
    assign trap_target = '0;
`endif

    // pick this cycle's incoming redirect: trap outranks jump
    always_comb begin
        fresh_kind   = NONE;
        fresh_target = jump_address;
        if (trap_req) begin
            fresh_kind   = TRAP;
            fresh_target = trap_target;
        end else if (jump_sign) begin
            fresh_kind   = JUMP;
        end
    end

    // redirects are parked only while stalled; leaving the stall empties the buffer
    always_comb begin
        buf_capture = live && hold_req && (fresh_kind != NONE);
        buf_clear   = live && !hold_req;
    end

    pc_redirect_buf #(
        .XLEN(XLEN)
    ) u_redirect_buf (
        .clk            (clk),
        .rst            (rst),
        .capture        (buf_capture),
        .capture_kind   (fresh_kind),
        .capture_target (fresh_target),
        .clear          (buf_clear),
        .pend_kind      (pend_kind),
        .pend_target    (pend_target)
    );

    // next state and next pc: fresh redirect, then pending, then sequential advance
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        misalign_d   = 1'b0;
        apply        = 1'b0;
        apply_target = fresh_target;
        case (state_q)
            RESET: state_d = BOOT;
            BOOT:  state_d = RUN;
            RUN, HOLD: begin
                if (hold_req) begin
                    state_d = HOLD;
                end else begin
                    state_d = RUN;
                    if (fresh_kind != NONE) begin
                        apply = 1'b1;
                    end else if (pend_kind != NONE) begin
                        apply        = 1'b1;
                        apply_target = pend_target;
                    end else if ((state_q == RUN) && fetch_ready) begin
                        pc_d = pc_q + STEP;
                    end
                end
            end
            default: state_d = RESET;
        endcase
        if (apply) begin
            pc_d       = apply_target & ALIGN_MASK;
            misalign_d = |(apply_target & ~ALIGN_MASK);
        end
    end

    // state, pc and misalign registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RESET;
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc          = pc_q;
    assign ce          = (state_q == RUN);
    assign fetch_valid = (state_q == RUN);
    assign misalign    = misalign_q;

endmodule
